// File: rtl/phase_osc_gen.sv
// Phase-offset square-wave generator for one oscillator neuron: a 50% duty output whose
// rising edge sits 'phase' steps after the shared step count wraps, retimed only at period ends.
module phase_osc_gen #(
    parameter int PW   = 4,
    parameter int DIV  = 1,
    parameter int DIVW = 4
) (
    input  logic          sclk,
    input  logic          re_n,
    input  logic          en,
    input  logic          ld,
    input  logic [PW-1:0] phi_in,
    output logic          nout,
    output logic          sof,
    output logic [PW-1:0] phase,
    output logic          pend
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [DIVW-1:0] PCNT_LAST = DIVW'(DIV - 1);
    localparam logic [PW-1:0]   CNT_LAST  = '1;

    state_t          state_q, state_d;
    logic [DIVW-1:0] pcnt_q, pcnt_d;
    logic [PW-1:0]   cnt_q, cnt_d;
    logic            nout_q, nout_d;
    logic            sof_q, sof_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [PW-1:0]   preg_q, preg_d;
    logic            pend_q, pend_d;

    logic            tick;
    logic            wrap;
    logic            apply;
    logic [PW-1:0]   diff;

    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        cnt_d   = cnt_q;
        nout_d  = nout_q;
        preg_d  = preg_q;
        phase_d = phase_q;
        pend_d  = pend_q;

        tick  = (state_q != IDLE) && (pcnt_q == PCNT_LAST);
        wrap  = tick && (cnt_q == CNT_LAST);
        diff  = cnt_q - phase_q;
        // In IDLE a pending phase is taken at once; while running only at the period boundary.
        apply = pend_q && ((state_q == IDLE) || ((state_q == RUN) && wrap));
        sof_d = wrap;

        case (state_q)
            IDLE: begin
                pcnt_d = '0;
                cnt_d  = '0;
                nout_d = 1'b0;
                if (en) state_d = RUN;
            end
            RUN, STOP: begin
                pcnt_d = tick ? '0 : pcnt_q + 1'b1;
                cnt_d  = cnt_q + PW'(tick);
                nout_d = ~diff[PW-1];
                if (state_q == RUN) begin
                    if (!en) state_d = STOP;
                end else if (en) begin
                    state_d = RUN;
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply) phase_d = preg_q;
        if (ld) begin
            preg_d = phi_in;
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or negedge re_n) begin
        if (!re_n) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            cnt_q   <= '0;
            nout_q  <= 1'b0;
            sof_q   <= 1'b0;
            phase_q <= '0;
            preg_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            cnt_q   <= cnt_d;
            nout_q  <= nout_d;
            sof_q   <= sof_d;
            phase_q <= phase_d;
            preg_q  <= preg_d;
            pend_q  <= pend_d;
        end
    end

    assign nout  = nout_q;
    assign sof   = sof_q;
    assign phase = phase_q;
    assign pend  = pend_q;

endmodule

// File: tb/tb_phase_osc_gen.sv
// Directed bench for phase_osc_gen: per-cycle vector table on a DIV=1 instance, then reset
// and DIV=3 period sequences.
module tb_phase_osc_gen;

    typedef struct {
        logic       en;
        logic       ld;
        logic [3:0] phi;
        int         reps;
        logic       nout;
        logic       sof;
        logic [3:0] phase;
        logic       pend;
    } vec_t;

    logic       sclk;
    logic       re_n;
    logic       en, ld;
    logic [3:0] phi_in;
    logic       nout, sof, pend;
    logic [3:0] phase;

    logic       en3, ld3;
    logic [3:0] phi3;
    logic       nout3, sof3, pend3;
    logic [3:0] phase3;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[$];

    phase_osc_gen #(.PW(4), .DIV(1), .DIVW(4)) dut (
        .sclk(sclk), .re_n(re_n), .en(en), .ld(ld), .phi_in(phi_in),
        .nout(nout), .sof(sof), .phase(phase), .pend(pend)
    );

    phase_osc_gen #(.PW(4), .DIV(3), .DIVW(4)) dut3 (
        .sclk(sclk), .re_n(re_n), .en(en3), .ld(ld3), .phi_in(phi3),
        .nout(nout3), .sof(sof3), .phase(phase3), .pend(pend3)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic e, input logic l, input logic [3:0] p, input int n,
                                    input logic no, input logic so, input logic [3:0] ph, input logic pe);
        vec_t v;
        v.en = e; v.ld = l; v.phi = p; v.reps = n;
        v.nout = no; v.sof = so; v.phase = ph; v.pend = pe;
        vecs.push_back(v);
    endfunction

    initial begin
        int hist_nout[1:100];
        int hist_sof[1:100];
        int first_rise, second_rise, first_fall, first_sof, second_sof, sof_count, high_count;

        // en, ld, phi, reps | nout, sof, phase, pend  (comments give step count before the edges)
        add_vec(1, 0, 0, 1, 0, 0, 0, 0); // IDLE -> RUN
        add_vec(1, 0, 0, 8, 1, 0, 0, 0); // cnt 0..7
        add_vec(1, 0, 0, 7, 0, 0, 0, 0); // cnt 8..14
        add_vec(1, 0, 0, 1, 0, 1, 0, 0); // cnt 15, wrap
        add_vec(1, 0, 0, 8, 1, 0, 0, 0); // cnt 0..7
        add_vec(1, 1, 4, 1, 0, 0, 0, 1); // cnt 8, load 4
        add_vec(1, 0, 0, 6, 0, 0, 0, 1); // cnt 9..14
        add_vec(1, 0, 0, 1, 0, 1, 4, 0); // cnt 15, apply 4
        add_vec(1, 0, 0, 4, 0, 0, 4, 0); // cnt 0..3
        add_vec(1, 0, 0, 8, 1, 0, 4, 0); // cnt 4..11
        add_vec(1, 1, 2, 1, 0, 0, 4, 1); // cnt 12, load 2
        add_vec(1, 1, 9, 1, 0, 0, 4, 1); // cnt 13, load 9 overwrites
        add_vec(1, 0, 0, 1, 0, 0, 4, 1); // cnt 14
        add_vec(1, 0, 0, 1, 0, 1, 9, 0); // cnt 15, apply 9
        add_vec(1, 0, 0, 1, 1, 0, 9, 0); // cnt 0
        add_vec(1, 0, 0, 8, 0, 0, 9, 0); // cnt 1..8
        add_vec(1, 0, 0, 3, 1, 0, 9, 0); // cnt 9..11
        add_vec(1, 1, 6, 1, 1, 0, 9, 1); // cnt 12, load 6
        add_vec(1, 0, 0, 2, 1, 0, 9, 1); // cnt 13..14
        add_vec(1, 1, 3, 1, 1, 1, 6, 1); // cnt 15, apply 6 while loading 3
        add_vec(1, 0, 0, 5, 0, 0, 6, 1); // cnt 0..4
        add_vec(0, 0, 0, 1, 0, 0, 6, 1); // cnt 5, en dropped
        add_vec(0, 0, 0, 8, 1, 0, 6, 1); // cnt 6..13 in STOP
        add_vec(0, 0, 0, 1, 0, 0, 6, 1); // cnt 14
        add_vec(0, 0, 0, 1, 0, 1, 6, 1); // cnt 15, STOP -> IDLE, no apply
        add_vec(0, 0, 0, 1, 0, 0, 3, 0); // IDLE applies 3
        add_vec(0, 0, 0, 4, 0, 0, 3, 0); // IDLE held
        add_vec(1, 0, 0, 1, 0, 0, 3, 0); // IDLE -> RUN
        add_vec(1, 0, 0, 3, 0, 0, 3, 0); // cnt 0..2
        add_vec(1, 0, 0, 8, 1, 0, 3, 0); // cnt 3..10
        add_vec(0, 0, 0, 1, 0, 0, 3, 0); // cnt 11, RUN -> STOP
        add_vec(1, 0, 0, 1, 0, 0, 3, 0); // cnt 12, STOP -> RUN
        add_vec(1, 0, 0, 2, 0, 0, 3, 0); // cnt 13..14
        add_vec(1, 0, 0, 1, 0, 1, 3, 0); // cnt 15, wrap uninterrupted
        add_vec(1, 0, 0, 3, 0, 0, 3, 0); // cnt 0..2
        add_vec(1, 1, 5, 1, 1, 0, 3, 1); // cnt 3, load 5
        add_vec(1, 0, 0, 6, 1, 0, 3, 1); // cnt 4..9

        re_n = 1'b1; en = 1'b0; ld = 1'b0; phi_in = '0;
        en3 = 1'b0; ld3 = 1'b0; phi3 = '0;
        #2 re_n = 1'b0;
        #1;
        check("reset nout", nout, 0);
        check("reset sof", sof, 0);
        check("reset phase", phase, 0);
        check("reset pend", pend, 0);
        check("reset nout3", nout3, 0);
        repeat (2) @(posedge sclk);
        @(negedge sclk) re_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                en     = vecs[i].en;
                ld     = (r == 0) ? vecs[i].ld : 1'b0;
                phi_in = vecs[i].phi;
                @(posedge sclk);
                #1;
                check($sformatf("vec%0d.%0d nout", i, r), nout, vecs[i].nout);
                check($sformatf("vec%0d.%0d sof", i, r), sof, vecs[i].sof);
                check($sformatf("vec%0d.%0d phase", i, r), phase, vecs[i].phase);
                check($sformatf("vec%0d.%0d pend", i, r), pend, vecs[i].pend);
            end
        end
        ld = 1'b0;

        // Reset at cnt 10 with nout high, phase 3 and a pending load: everything clears at once.
        re_n = 1'b0;
        #1;
        check("midreset nout", nout, 0);
        check("midreset sof", sof, 0);
        check("midreset phase", phase, 0);
        check("midreset pend", pend, 0);
        repeat (2) begin
            @(posedge sclk);
            #1;
            check("held reset nout", nout, 0);
        end
        @(negedge sclk) re_n = 1'b1;
        @(posedge sclk);
        #1;
        check("restart first edge nout", nout, 0);
        @(posedge sclk);
        #1;
        check("restart cnt0 nout", nout, 1);
        check("restart phase", phase, 0);
        check("restart pend", pend, 0);
        en = 1'b0;

        // DIV=3: 16 steps of 3 sclk each.
        en3 = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge sclk);
            #1;
            hist_nout[k] = int'(nout3);
            hist_sof[k]  = int'(sof3);
        end
        en3 = 1'b0;

        first_rise = 0; second_rise = 0; first_fall = 0;
        first_sof = 0; second_sof = 0; sof_count = 0; high_count = 0;
        for (int k = 1; k <= 100; k++) begin
            if (hist_nout[k] == 1 && (k == 1 || hist_nout[k-1] == 0)) begin
                if (first_rise == 0) first_rise = k;
                else if (second_rise == 0) second_rise = k;
            end
            if (first_rise != 0 && first_fall == 0 && hist_nout[k] == 0) first_fall = k;
            if (hist_sof[k] == 1) begin
                sof_count++;
                if (first_sof == 0) first_sof = k;
                else if (second_sof == 0) second_sof = k;
            end
            if (k >= 2 && k <= 49 && hist_nout[k] == 1) high_count++;
        end
        check("div3 first rise", first_rise, 2);
        check("div3 first fall", first_fall, 26);
        check("div3 high count", high_count, 24);
        check("div3 second rise", second_rise, 50);
        check("div3 first sof", first_sof, 49);
        check("div3 second sof", second_sof, 97);
        check("div3 sof count", sof_count, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
